// File: rtl/asic_sr_driver_if.sv
// Byte-stream, control and shift-register pins of the ASIC config SR driver.
// The controller side uses master; the driver uses slave.
`timescale 1ns/1ps
interface asic_sr_driver_if #(
    parameter int LEN_W = 16,
    parameter int DIV_W = 8
);
    logic [DIV_W-1:0] clk_div;
    logic [LEN_W-1:0] bit_count;
    logic             start;
    logic             abort;
    logic [7:0]       din;
    logic             din_valid;
    logic             din_ready;
    logic             sr_sin;
    logic             sr_ck1;
    logic             sr_ck2;
    logic             sr_ld;
    logic             busy;
    logic             done;

    modport master (
        output clk_div, bit_count, start, abort, din, din_valid,
        input  din_ready, sr_sin, sr_ck1, sr_ck2, sr_ld, busy, done
    );

    modport slave (
        input  clk_div, bit_count, start, abort, din, din_valid,
        output din_ready, sr_sin, sr_ck1, sr_ck2, sr_ld, busy, done
    );
endinterface

// File: rtl/asic_sr_driver.sv
// ASIC configuration shift-register driver: shifts bytes MSB-first with two
// non-overlapping clocks, each phase clk_div+1 cycles, then pulses the load strobe.
`timescale 1ns/1ps
module asic_sr_driver #(
    parameter int LEN_W = 16,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             res_n,
    asic_sr_driver_if.slave  sr
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_P0, S_P1, S_P2, S_P3, S_LD0, S_LD1, S_LD2
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] ph_q, ph_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       byte_q, byte_d;
    logic             sin_q, sin_d;
    logic             ck1_q, ck1_d;
    logic             ck2_q, ck2_d;
    logic             ld_q, ld_d;
    logic             rdy_q, rdy_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ph_end;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        ph_d    = ph_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        byte_d  = byte_q;
        done_d  = 1'b0;
        ph_end  = (ph_q == div_q);

        if (sr.abort) begin
            // Abort beats start and any pending transition; IDLE stays untouched.
            if (state_q != S_IDLE) begin
                state_d = S_IDLE;
                ph_d    = '0;
                rem_d   = '0;
                idx_d   = '0;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (sr.start) begin
                        div_d   = sr.clk_div;
                        rem_d   = sr.bit_count;
                        ph_d    = '0;
                        idx_d   = 3'd7;
                        state_d = (sr.bit_count == '0) ? S_LD0 : S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (sr.din_valid) begin
                        byte_d  = sr.din;
                        idx_d   = 3'd7;
                        ph_d    = '0;
                        state_d = S_P0;
                    end
                end
                default: begin
                    if (!ph_end) begin
                        ph_d = ph_q + DIV_W'(1);
                    end else begin
                        ph_d = '0;
                        unique case (state_q)
                            S_P0:  state_d = S_P1;
                            S_P1:  state_d = S_P2;
                            S_P2:  state_d = S_P3;
                            S_P3: begin
                                rem_d = rem_q - LEN_W'(1);
                                // A partial last byte ends here without another fetch.
                                if (rem_q == LEN_W'(1)) begin
                                    state_d = S_LD0;
                                end else if (idx_q == 3'd0) begin
                                    state_d = S_FETCH;
                                end else begin
                                    idx_d   = idx_q - 3'd1;
                                    state_d = S_P0;
                                end
                            end
                            S_LD0: state_d = S_LD1;
                            S_LD1: state_d = S_LD2;
                            S_LD2: begin
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                            end
                            default: state_d = S_IDLE;
                        endcase
                    end
                end
            endcase
        end

        // Outputs are decoded from the next state so they register in step with it.
        busy_d = (state_d != S_IDLE);
        rdy_d  = (state_d == S_FETCH);
        ck1_d  = (state_d == S_P1);
        ck2_d  = (state_d == S_P3);
        ld_d   = (state_d == S_LD1);
        sin_d  = (state_d inside {S_P0, S_P1, S_P2, S_P3}) ? byte_d[idx_d] : 1'b0;
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            ph_q    <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            byte_q  <= '0;
            sin_q   <= 1'b0;
            ck1_q   <= 1'b0;
            ck2_q   <= 1'b0;
            ld_q    <= 1'b0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            ph_q    <= ph_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
            sin_q   <= sin_d;
            ck1_q   <= ck1_d;
            ck2_q   <= ck2_d;
            ld_q    <= ld_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sr.sr_sin    = sin_q;
    assign sr.sr_ck1    = ck1_q;
    assign sr.sr_ck2    = ck2_q;
    assign sr.sr_ld     = ld_q;
    assign sr.din_ready = rdy_q;
    assign sr.busy      = busy_q;
    assign sr.done      = done_q;

endmodule

// File: tb/tb_asic_sr_driver.sv
// Bench for asic_sr_driver: byte feeder with stall injection, negedge waveform
// monitor, and per-transfer expectations derived from bytes, length and divider.
`timescale 1ns/1ps
module tb_asic_sr_driver;

    logic clk = 1'b0;
    logic res_n = 1'b1;
    always #5 clk = ~clk;

    asic_sr_driver_if #(.LEN_W(16), .DIV_W(8)) ifc ();
    asic_sr_driver #(.LEN_W(16), .DIV_W(8)) dut (.clk(clk), .res_n(res_n), .sr(ifc.slave));

    int checks = 0;
    int errors = 0;

    logic [7:0] pat[$];
    logic [7:0] fq[$];
    int  n_hs, stall_idx, stall_left, T_mon;
    bit  hs_pend;
    int  cyc, busy_n, busy_rise, fetch_n, rdy_clk, ovl;
    int  ck1_n, ck2_n, run1, run2, fall1, werr, gap_err, hold_err;
    int  ld_n, ld_cyc, ld_off, ld_sin, done_n, done_ok, nbits;
    logic [63:0] got_bits;
    logic last_bit, p_ck1, p_ck2, p_ld, p_busy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] outv();
        return {ifc.sr_sin, ifc.sr_ck1, ifc.sr_ck2, ifc.sr_ld, ifc.din_ready, ifc.busy, ifc.done};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        n_hs = 0; stall_idx = -1; stall_left = 0; hs_pend = 0;
        busy_n = 0; busy_rise = 0; fetch_n = 0; rdy_clk = 0; ovl = 0;
        ck1_n = 0; ck2_n = 0; run1 = 0; run2 = 0; fall1 = 0; werr = 0; gap_err = 0; hold_err = 0;
        ld_n = 0; ld_cyc = 0; ld_off = 0; ld_sin = 0; done_n = 0; done_ok = 0; nbits = 0;
        got_bits = '0;
    endtask

    // Feeder and monitor share the negedge so the initial block (posedge+1) never races them.
    always @(negedge clk) begin
        bit stalling;
        cyc++;
        if (hs_pend) begin
            if (fq.size() > 0) void'(fq.pop_front());
            n_hs++;
        end
        stalling = (n_hs == stall_idx) && (stall_left > 0);
        if (stalling && ifc.din_ready) stall_left--;
        if (fq.size() > 0 && !stalling) begin
            ifc.din = fq[0];
            ifc.din_valid = 1'b1;
        end else begin
            ifc.din_valid = 1'b0;
        end
        hs_pend = ifc.din_valid && ifc.din_ready;

        if (ifc.busy) busy_n++;
        if (ifc.busy && !p_busy) busy_rise = cyc;
        if (ifc.din_ready) fetch_n++;
        if (ifc.din_ready && (ifc.sr_ck1 || ifc.sr_ck2 || ifc.sr_ld)) rdy_clk++;
        if (int'(ifc.sr_ck1) + int'(ifc.sr_ck2) + int'(ifc.sr_ld) > 1) ovl++;
        if (ifc.sr_ck1 && !p_ck1) begin
            ck1_n++; run1 = 0; nbits++;
            got_bits = {got_bits[62:0], ifc.sr_sin};
            last_bit = ifc.sr_sin;
        end
        if (ifc.sr_ck1) run1++;
        if (!ifc.sr_ck1 && p_ck1) begin
            if (run1 != T_mon) werr++;
            fall1 = cyc;
        end
        if (ifc.sr_ck2 && !p_ck2) begin
            ck2_n++; run2 = 0;
            if (cyc - fall1 != T_mon) gap_err++;
        end
        if (ifc.sr_ck2) begin
            run2++;
            if (ifc.sr_sin !== last_bit) hold_err++;
        end
        if (!ifc.sr_ck2 && p_ck2 && run2 != T_mon) werr++;
        if (ifc.sr_ld && !p_ld) begin ld_n++; ld_off = cyc - busy_rise; end
        if (ifc.sr_ld) begin ld_cyc++; if (ifc.sr_sin) ld_sin++; end
        if (ifc.done) begin done_n++; if (p_busy && !ifc.busy) done_ok++; end
        p_ck1 = ifc.sr_ck1; p_ck2 = ifc.sr_ck2; p_ld = ifc.sr_ld; p_busy = ifc.busy;
    end

    // One full transfer of pat; expectations come from the bit/phase arithmetic alone.
    task automatic run(input string tag, input int div, input int n,
                       input int st_i, input int st_n, input bit collide);
        int T, nb, exp_fetch, exp_busy;
        logic [63:0] exp_bits;
        T = div + 1;
        nb = (n + 7) / 8;
        exp_fetch = nb + ((st_i >= 0 && st_i < nb) ? st_n : 0);
        exp_busy = exp_fetch + 4 * T * n + 3 * T;
        exp_bits = '0;
        for (int i = 0; i < n; i++) exp_bits = {exp_bits[62:0], pat[i / 8][7 - (i % 8)]};
        clear_mon();
        fq = pat;
        stall_idx = st_i;
        stall_left = st_n;
        T_mon = T;
        ifc.clk_div = 8'(div);
        ifc.bit_count = 16'(n);
        ifc.start = 1'b1;
        step();
        ifc.start = 1'b0;
        for (int i = 0; i < exp_busy + 40 && done_n == 0; i++) begin
            if (collide && i == 3) begin
                ifc.start = 1'b1; ifc.bit_count = 16'(n + 9); ifc.clk_div = 8'(div + 2);
            end else begin
                ifc.start = 1'b0;
            end
            step();
        end
        ifc.start = 1'b0;
        repeat (3) step();
        chk({tag, "_done"}, done_n, 1);
        chk({tag, "_done_after_busy"}, done_ok, 1);
        chk({tag, "_busy_len"}, busy_n, exp_busy);
        chk({tag, "_handshakes"}, n_hs, nb);
        chk({tag, "_fetch_cycles"}, fetch_n, exp_fetch);
        chk({tag, "_ck1_pulses"}, ck1_n, n);
        chk({tag, "_ck2_pulses"}, ck2_n, n);
        chk({tag, "_bits"}, got_bits, exp_bits);
        chk({tag, "_ld_pulses"}, ld_n, 1);
        chk({tag, "_ld_width"}, ld_cyc, T);
        chk({tag, "_ld_offset"}, ld_off, exp_fetch + 4 * T * n + T);
        chk({tag, "_width_gap_err"}, werr + gap_err, 0);
        chk({tag, "_overlap_rdyclk"}, ovl + rdy_clk, 0);
        chk({tag, "_sin_hold_ld"}, hold_err + ld_sin, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, div, n;
        bit found, pk;
        ifc.clk_div = '0; ifc.bit_count = '0; ifc.start = 1'b0; ifc.abort = 1'b0;
        ifc.din = '0; ifc.din_valid = 1'b0;
        cyc = 0; p_ck1 = 0; p_ck2 = 0; p_ld = 0; p_busy = 0; last_bit = 0;
        clear_mon();
        T_mon = 1;

        #1 res_n = 1'b0;
        #2 chk("reset_outputs", outv(), 7'd0);
        step();
        res_n = 1'b1;
        step();
        chk("idle_outputs", outv(), 7'd0);

        pat = '{8'hA5};
        run("single_a5", 0, 8, -1, 0, 0);

        pat = '{8'hF0, 8'h3C};
        run("div3_partial", 3, 12, -1, 0, 0);

        pat = '{8'h96, 8'h6B};
        run("starve", 1, 16, 1, 50, 0);

        pat.delete();
        run("zero_len", 1, 0, -1, 0, 0);

        for (int k = 0; k < 3; k++) begin
            div = $urandom_range(0, 3);
            n = $urandom_range(1, 40);
            pat.delete();
            for (int b = 0; b < 6; b++) pat.push_back(8'($urandom));
            run($sformatf("rand%0d", k), div, n, (k == 2) ? 0 : -1, $urandom_range(1, 9), 0);
        end

        pat = '{8'h5A, 8'hC3};
        run("collide", 1, 10, -1, 0, 1);

        // Abort while ck1 of the fourth bit (index 3) is high.
        pat = '{8'hC3, 8'h5A};
        clear_mon();
        fq = pat;
        T_mon = 2;
        ifc.clk_div = 8'd1; ifc.bit_count = 16'd16; ifc.start = 1'b1;
        step();
        ifc.start = 1'b0;
        r = 0; pk = 0; found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (ifc.sr_ck1 && !pk) r++;
            pk = ifc.sr_ck1;
            if (ifc.sr_ck1 && r == 4) found = 1;
        end
        chk("abort_reach_bit3", found, 1);
        ifc.abort = 1'b1;
        step();
        ifc.abort = 1'b0;
        chk("abort_outputs", outv(), 7'd0);
        repeat (10) step();
        chk("abort_no_done", done_n, 0);
        chk("abort_no_ld", ld_n, 0);

        ifc.abort = 1'b1; ifc.start = 1'b1; ifc.bit_count = 16'd4;
        step();
        ifc.abort = 1'b0; ifc.start = 1'b0;
        chk("abort_start_busy", ifc.busy, 1'b0);
        step();
        chk("abort_start_dropped", ifc.busy, 1'b0);

        pat = '{8'h3E, 8'h81};
        run("post_abort", 0, 16, -1, 0, 0);

        // Asynchronous reset in the middle of a cycle.
        pat = '{8'hFF, 8'hFF};
        clear_mon();
        fq = pat;
        ifc.clk_div = 8'd0; ifc.bit_count = 16'd16; ifc.start = 1'b1;
        step();
        ifc.start = 1'b0;
        repeat (6) step();
        chk("rst_pre_busy", ifc.busy, 1'b1);
        #2 res_n = 1'b0;
        #1 chk("rst_async_outputs", outv(), 7'd0);
        step();
        step();
        res_n = 1'b1;
        step();
        chk("rst_release_idle", outv(), 7'd0);

        pat = '{8'h71};
        run("post_reset", 2, 5, -1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/asic_sr_driver.md
Name: asic_sr_driver

Overview:
- Drives the ASIC configuration shift register: sr_sin, two non-overlapping shift clocks sr_ck1/sr_ck2, and the sr_ld load strobe.
- Consumes configuration bytes from the FTDI command path through a valid/ready byte stream and shifts a programmed number of bits MSB-first.
- Ends every transfer with a load pulse.
- Its outputs feed the config LVDS/SE output buffers and the SR readback monitor.

Parameters:
- LEN_W, 16, width of bit_count (max 65535 bits per transfer)
- DIV_W, 8, width of clk_div

Ports:
- clk  in  1  system clock
- res_n  in  1  asynchronous active-low reset
- clk_div  in  DIV_W  phase length minus one, in clk cycles; sampled on start
- bit_count  in  LEN_W  number of bits to shift; sampled on start
- start  in  1  single-cycle transfer request
- abort  in  1  abandon transfer immediately
- din  in  8  config byte, MSB shifted first
- din_valid  in  1  byte available
- din_ready  out  1  byte accepted when din_valid & din_ready
- sr_sin  out  1  serial data to ASIC
- sr_ck1  out  1  shift clock phase 1
- sr_ck2  out  1  shift clock phase 2
- sr_ld  out  1  load strobe
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: asynchronous, active-low.
  - Outputs: sr_sin=0, sr_ck1=0, sr_ck2=0, sr_ld=0, din_ready=0, busy=0, done=0.
  - State: IDLE; all counters 0.
- Phase length T = clk_div+1 cycles. clk_div=0 gives T=1; clk_div=255 gives T=256.
- All outputs are registered.
- Only one of sr_ck1, sr_ck2, sr_ld is ever high at a time.
- IDLE:
  - start=1 latches clk_div and bit_count, then sets busy=1 from the next cycle.
  - If bit_count=0, go to LD0; otherwise go to FETCH.
  - start while busy is ignored.
- FETCH:
  - din_ready=1, all clocks low.
  - Stays until din_valid; the byte is captured on the handshake edge.
  - Next state: P0 with bit index 7.
  - din_ready is high only in FETCH; no prefetch.
- Per-bit sequence, each phase exactly T cycles:
  - P0: sr_sin = byte[idx], clocks low (setup).
  - P1: sr_ck1=1.
  - P2: clocks low.
  - P3: sr_ck2=1.
  - sr_sin holds its value from P0 through P3.
- After P3:
  - Decrement the remaining-bits counter.
  - If remaining=0, go to LD0.
  - Else if idx=0, go to FETCH.
  - Else decrement idx and go to P0.
- Partial last byte: unshifted low-order bits are discarded, and no further byte is requested.
- Load sequence, each phase T cycles:
  - LD0: all low.
  - LD1: sr_ld=1.
  - LD2: all low.
  - Then IDLE, with done=1 for exactly one cycle (busy=0 in that cycle).
  - sr_sin is 0 from LD0 onward.
- Starvation: din_valid low in FETCH holds the state with clocks low indefinitely. No timeout. The next bit's P0 starts the cycle after the handshake.
- abort:
  - Has priority over everything, in any state.
  - Next cycle: IDLE, all outputs 0, done not pulsed.
  - A concurrent handshake in FETCH still consumes that byte.
  - abort in IDLE has no effect.
  - abort and start together: abort wins and start is dropped.
- Timing totals:
  - Busy duration = (number of FETCH cycles) + 4T·bit_count + 3T.
  - Example, clk_div=0, bit_count=8, byte ready: 1+32+3 = 36 cycles.
- Phase counter: DIV_W bits, counts 0..clk_div, then advances the state.

Test Plan:
- Single byte:
  - Stimulus: clk_div=0, bit_count=8, din=0xA5 always valid, start pulse.
  - Response: sr_sin per bit 1,0,1,0,0,1,0,1. Eight 1-cycle ck1 and eight 1-cycle ck2 pulses, never overlapping. One 1-cycle sr_ld. busy high 36 cycles, then done high 1 cycle.
- Divider and partial byte:
  - Stimulus: clk_div=3, bit_count=12, bytes 0xF0,0x3C.
  - Response: bits 1111 0000 0011. Every phase 4 cycles wide. Exactly 2 handshakes. busy = 2 + 192 + 12 = 206 cycles.
- Starvation:
  - Stimulus: bit_count=16; hold din_valid low for 50 cycles at the second FETCH.
  - Response: din_ready high and all clocks low throughout the stall. Shifting resumes the cycle after valid. Final sr_sin sequence is correct.
- Zero length:
  - Stimulus: bit_count=0, clk_div=1, start.
  - Response: no ck1/ck2 pulses and no din_ready. sr_ld high 2 cycles after 2 low cycles. done pulse after 6 busy cycles.
- Abort:
  - Stimulus: abort during P1 of bit 3.
  - Response: next cycle all outputs 0, no done, no sr_ld. A subsequent start runs a normal transfer.
- Reset and collisions:
  - Stimulus: res_n low mid-transfer.
  - Response: outputs zero asynchronously, without waiting for a clk edge.
  - Stimulus: start while busy.
  - Response: ignored, and the transfer length is unchanged.
